// File: rtl/blink_pkg.sv
// Shared constants for the LED blink driver and its input conditioner, so
// both agree on the system clock rate and the debounce window.
`timescale 1ns/1ps
package blink_pkg;

  localparam int CLK_HZ                  = 25000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Width of a counter that must hold 0 .. n-1, never narrower than 1 bit.
  function automatic int count_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser followed by a persistence counter.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronised
// samples differ from the current stable level.
`timescale 1ns/1ps
module debounce_channel
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CW        = count_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   COUNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] count;
  logic          accept;

  // The candidate level has persisted long enough on this edge.
  assign accept   = (sync2 != stable) && (count == COUNT_MAX);
  assign o_rise   = accept & sync2;
  assign o_fall   = accept & ~sync2;
  assign o_stable = stable;

  // Synchronise the raw input and qualify each change with the counter.
  always_ff @(posedge i_clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // sync1 -> sync2 only forms a two-stage chain because of this.
    if (i_reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      count  <= '0;
    end else begin
      sync1 <= i_raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        count <= '0;
      end else if (accept) begin
        stable <= sync2;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the raw board switches and enable push-button for the blink
// driver: debounced switch levels, a toggling enable level, and one-cycle
// strobes for button presses and mode changes.
`timescale 1ns/1ps
module switch_conditioner
  import blink_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic ENABLE_RESET    = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_switch_1_raw,
  input  logic i_switch_2_raw,
  input  logic i_button_raw,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_enable,
  output logic o_press,
  output logic o_mode_change
);

  logic switch_1_rise, switch_1_fall;
  logic switch_2_rise, switch_2_fall;
  logic button_stable, button_rise, button_fall;
  logic mode_accept;

  logic enable;
  logic press;
  logic mode_change;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_switch_1 (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_raw    (i_switch_1_raw),
    .o_stable (o_switch_1),
    .o_rise   (switch_1_rise),
    .o_fall   (switch_1_fall)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_switch_2 (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_raw    (i_switch_2_raw),
    .o_stable (o_switch_2),
    .o_rise   (switch_2_rise),
    .o_fall   (switch_2_fall)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_raw    (i_button_raw),
    .o_stable (button_stable),
    .o_rise   (button_rise),
    .o_fall   (button_fall)
  );

  // Either switch accepting on the same edge yields a single strobe.
  assign mode_accept = switch_1_rise | switch_1_fall | switch_2_rise | switch_2_fall;

  // Enable toggles on accepted presses only; strobes last one cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      enable      <= ENABLE_RESET;
      press       <= 1'b0;
      mode_change <= 1'b0;
    end else begin
      press       <= button_rise;
      mode_change <= mode_accept;
      if (button_rise) begin
        enable <= ~enable;
      end
    end
  end

  // A channel accepts at most one direction per edge, matching its stable level.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      assert (!(button_rise && button_fall) && !(button_rise && button_stable))
        else $error("button channel accept inconsistent");
    end
  end

  assign o_enable      = enable;
  assign o_press       = press;
  assign o_mode_change = mode_change;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with DEBOUNCE_CYCLES = 4 and a 40 us clock:
// a vector table, directed corner-case sequences, and randomized traffic
// compared against a window-based reference model.
`timescale 1ns/1ps
module tb_switch_conditioner;

  localparam int D = 4;

  logic clock = 1'b0;
  logic reset;
  logic sw1_raw, sw2_raw, btn_raw;
  logic sw1, sw2, en, press, mc;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #20000 clock = ~clock;

  switch_conditioner #(.DEBOUNCE_CYCLES(D), .ENABLE_RESET(1'b1)) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_switch_1_raw (sw1_raw),
    .i_switch_2_raw (sw2_raw),
    .i_button_raw   (btn_raw),
    .o_switch_1     (sw1),
    .o_switch_2     (sw2),
    .o_enable       (en),
    .o_press        (press),
    .o_mode_change  (mc)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {sw1, sw2, en, press, mc};
  endfunction

  // Reference model: a channel accepts when its last D synchronised samples
  // since reset all differ from the current stable level. Synchronised
  // sample = raw value delayed by two edges. raw[0]=sw1, [1]=sw2, [2]=button.
  logic [2:0] m_p1 = '0, m_p2 = '0, m_stable = '0;
  logic       m_en = 1'b1, m_press = 1'b0, m_mc = 1'b0;
  bit         win[3][$];

  task automatic model_edge(input logic rst, input logic [2:0] raw);
    logic [2:0] acc;
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_stable = '0;
      m_en = 1'b1; m_press = 1'b0; m_mc = 1'b0;
      for (int i = 0; i < 3; i++) win[i].delete();
    end else begin
      acc = '0;
      for (int i = 0; i < 3; i++) begin
        bit all_new;
        win[i].push_back(m_p2[i]);
        if (win[i].size() > D) void'(win[i].pop_front());
        all_new = (win[i].size() == D);
        for (int j = 0; j < win[i].size(); j++)
          if (win[i][j] == m_stable[i]) all_new = 1'b0;
        acc[i] = all_new;
      end
      m_press  = acc[2] && !m_stable[2];
      m_en     = m_en ^ m_press;
      m_mc     = acc[0] | acc[1];
      m_stable = m_stable ^ acc;
      m_p2     = m_p1;
      m_p1     = raw;
    end
  endtask

  // Drive one cycle, advance the model, and compare just after mid-cycle.
  task automatic step(input logic rst, input logic [2:0] raw);
    reset   = rst;
    sw1_raw = raw[0];
    sw2_raw = raw[1];
    btn_raw = raw[2];
    model_edge(rst, raw);
    @(posedge clock);
    @(negedge clock);
    check($sformatf("model@%0d", cyc), int'(outs()),
          int'({m_stable[0], m_stable[1], m_en, m_press, m_mc}));
    cyc++;
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] raw;
    logic [4:0] exp;   // {sw1, sw2, en, press, mc}
  } vec_t;

  vec_t tbl[17];

  initial begin
    int         k_rise;
    int         cnt;
    bit         seen;
    logic [2:0] raw;
    logic [1:0] code_seq[3];

    reset = 1'b1; sw1_raw = 1'b0; sw2_raw = 1'b0; btn_raw = 1'b0;

    // Reset with all raws high, release, all channels accept on edge N+5,
    // then all raws low and all channels fall on edge N+5 again.
    for (int i = 0; i < 3;  i++) tbl[i] = '{1'b1, 3'b111, 5'b00100};
    for (int i = 3; i < 8;  i++) tbl[i] = '{1'b0, 3'b111, 5'b00100};
    tbl[8] = '{1'b0, 3'b111, 5'b11011};
    tbl[9] = '{1'b0, 3'b111, 5'b11000};
    for (int i = 10; i < 15; i++) tbl[i] = '{1'b0, 3'b000, 5'b11000};
    tbl[15] = '{1'b0, 3'b000, 5'b00001};
    tbl[16] = '{1'b0, 3'b000, 5'b00000};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].raw);
      check($sformatf("table[%0d]", i), int'(outs()), int'(tbl[i].exp));
    end

    // Glitch rejection on switch 2: 3 high, 1 low, 3 high, then low.
    seen = 1'b0; cnt = 0;
    for (int i = 0; i < 15; i++) begin
      raw = (i < 3 || (i >= 4 && i < 7)) ? 3'b010 : 3'b000;
      step(1'b0, raw);
      if (sw2) seen = 1'b1;
      cnt += int'(mc);
    end
    check("glitch_sw2", int'(seen), 0);
    check("glitch_mc", cnt, 0);

    // Clean change on switch 1: rises on edge N+5 with one strobe.
    k_rise = -1; cnt = 0; seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 3'b001);
      if (sw1 && k_rise < 0) k_rise = k;
      if (sw2) seen = 1'b1;
      cnt += int'(mc);
    end
    check("clean_latency", k_rise, 5);
    check("clean_mc_pulses", cnt, 1);
    check("clean_sw2_held", int'(seen), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000);

    // Bouncing button: one press, enable 1 -> 0, release does not toggle.
    step(1'b1, 3'b000);
    check("button_en_reset", int'(en), 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i % 2 == 0) ? 3'b100 : 3'b000);
      cnt += int'(press);
    end
    check("bounce_no_press", cnt, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'b100);
      cnt += int'(press);
    end
    check("button_press_once", cnt, 1);
    check("button_en_toggled", int'(en), 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'b000);
      cnt += int'(press);
    end
    check("release_no_press", cnt, 1);
    check("release_en_held", int'(en), 0);

    // Simultaneous switches, then walk the mode codes 11 -> 10 -> 01 -> 00.
    seen = 1'b0; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'b011);
      if (!seen && (sw1 || sw2)) begin
        seen = 1'b1;
        check("simul_same_edge", int'({sw1, sw2}), 3);
      end
      cnt += int'(mc);
    end
    check("simul_seen", int'(seen), 1);
    check("simul_mc_single", cnt, 1);
    code_seq[0] = 2'b10; code_seq[1] = 2'b01; code_seq[2] = 2'b00;
    for (int c = 0; c < 3; c++) begin
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        step(1'b0, {1'b0, code_seq[c][0], code_seq[c][1]});
        cnt += int'(mc);
      end
      check($sformatf("walk_code[%0d]", c), int'({sw1, sw2}), int'(code_seq[c]));
      check($sformatf("walk_mc[%0d]", c), cnt, 1);
    end

    // Reset mid-count discards the pending rise; re-qualified afterwards.
    step(1'b0, 3'b001);
    step(1'b0, 3'b001);
    step(1'b1, 3'b001);
    check("midreset_sw1_low", int'(sw1), 0);
    k_rise = -1;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 3'b001);
      if (sw1 && k_rise < 0) k_rise = k;
    end
    check("midreset_latency", k_rise, 5);

    // Randomized traffic: sparse toggles plus occasional reset.
    raw = 3'b000;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      step(($urandom_range(0, 299) == 0), raw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Input-conditioning stage that sits directly upstream of the LED blink driver. Takes the raw, asynchronous, bouncing board switches and the enable push-button. Produces the clean, synchronous levels that feed the driver's i_switch_1, i_switch_2 and i_enable inputs, plus single-cycle event strobes. Each input is synchronised, then debounced with a persistence counter. The push-button is turned into a toggling enable level.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250, consecutive synchronised cycles an input must hold a new value before it is accepted (10 ms at the 25 kHz system clock); legal range ≥ 1
- ENABLE_RESET, 1'b1, value of o_enable after reset

Ports:
- Clocking: one clock. Reset is synchronous and active-high.
- i_clock  input  1  system clock (25 kHz)
- i_reset  input  1  synchronous, active-high reset
- i_switch_1_raw  input  1  raw asynchronous switch 1
- i_switch_2_raw  input  1  raw asynchronous switch 2
- i_button_raw  input  1  raw asynchronous enable push-button, 1 = pressed
- o_switch_1  output  1  debounced switch 1 level, to blink i_switch_1
- o_switch_2  output  1  debounced switch 2 level, to blink i_switch_2
- o_enable  output  1  toggling enable level, to blink i_enable
- o_press  output  1  one-cycle pulse on each accepted button press
- o_mode_change  output  1  one-cycle pulse when o_switch_1 or o_switch_2 changes

## Operation
- Three identical channels: switch 1, switch 2 and button. Each channel has:
  - a 2-flop synchroniser (sync1, sync2)
  - a stable register
  - a counter of width $clog2(DEBOUNCE_CYCLES), minimum 1 bit
- Per channel, every clock edge:
  - If sync2 == stable: count <= 0.
  - If sync2 != stable and count == DEBOUNCE_CYCLES-1: stable <= sync2, count <= 0, and the channel asserts its accept signal for that edge.
  - Otherwise: count <= count + 1.
- Any sample where sync2 equals stable restarts the count. A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
- o_switch_1 and o_switch_2 are the stable registers of their channels.
- o_mode_change is registered and set on the edge where either switch channel accepts.
  - If both switch channels accept on the same edge, there is a single pulse.
  - If they accept on different edges, there is one pulse per edge.
- Button channel:
  - On the edge where it accepts a 0→1 transition, o_enable <= ~o_enable and o_press <= 1.
  - A 1→0 acceptance produces no pulse and no toggle.
- o_press and o_mode_change are 0 on every edge not listed above.
- No state machine beyond the per-channel counter. Channels are fully independent.

## Timing
- Reset values:
  - o_switch_1 = 0, o_switch_2 = 0, o_enable = ENABLE_RESET, o_press = 0, o_mode_change = 0
  - all sync flops = 0, all stable registers = 0, all counters = 0
- Reset mid-count discards the pending transition. A raw input held high through reset is re-qualified from zero after reset releases.
- Latency: raw input changes before sampling edge N and then holds.
  - sync2 takes the new value after edge N+1.
  - The stable output changes on edge N+DEBOUNCE_CYCLES+1.
  - o_press / o_mode_change are high for exactly the cycle after that edge.
- DEBOUNCE_CYCLES = 1: output follows the input 2 edges after sampling, with no filtering beyond synchronisation.
- Counter never wraps. Maximum value is DEBOUNCE_CYCLES-1.
- Outputs are all registered. No combinational path from any input to any output.

## Structure
- Shared package blink_pkg:
  - CLK_HZ = 25000
  - DEBOUNCE_MS = 10
  - derived DEBOUNCE_CYCLES default
- Debounce constants live in blink_pkg so that blink and this block agree on the clock rate.
- Sub-module debounce_channel (parameter DEBOUNCE_CYCLES):
  - ports: i_clock, i_reset, i_raw, o_stable, o_rise, o_fall
  - instantiated three times
  - top level adds the enable toggle, o_press and o_mode_change registers
- Expected size: ~60 lines for debounce_channel, ~80 lines for the top level.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and a 40 µs clock period.
1. Reset: hold i_reset 3 cycles with all raw inputs = 1 → o_switch_1 = o_switch_2 = 0, o_enable = 1, o_press = o_mode_change = 0. After release, o_switch_1 rises exactly 5 edges after the first sampling edge.
2. Glitch rejection: i_switch_2_raw pulses high for 3 cycles, low 1 cycle, high 3 cycles, then low → o_switch_2 stays 0 and o_mode_change never pulses.
3. Clean change: i_switch_1_raw 0→1 and held → o_switch_1 = 1 on edge N+5. o_mode_change is high for exactly one cycle. o_switch_2 is unchanged.
4. Bouncing button: i_button_raw toggles every cycle for 10 cycles, then holds 1 for 8 cycles, then holds 0 → exactly one o_press pulse and o_enable 1→0. The release does not toggle o_enable.
5. Simultaneous switches: both switch raws 0→1 on the same cycle and held → both outputs change on the same edge with a single o_mode_change pulse. Then the {1,1}→{0,0} switch sequence walks all four mode codes that blink consumes.
6. Reset mid-count: raw switch 1 goes high, and i_reset is asserted 2 cycles later for 1 cycle → o_switch_1 stays 0 through reset. It rises 5 edges after the first post-reset sampling edge.
